// File: rtl/func_sweep_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | func_sweep_checker: exhaustive sweep of N_FUNC N_IN-input functions vs a  |
// | golden truth table latched at start.                    Revision: 1.0    |
// +--------------------------------------------------------------------------+
module func_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int N_FUNC = 3,
  parameter int SETTLE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [(1<<N_IN)-1:0]       golden_i,
  input  logic [N_FUNC-1:0]          f_in_i,
  output logic [N_IN-1:0]            x_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       aborted_o,
  output logic [N_FUNC-1:0]          pass_o,
  output logic [N_FUNC*(N_IN+1)-1:0] err_cnt_o,
  output logic [N_FUNC-1:0]          first_fail_vld_o,
  output logic [N_FUNC*N_IN-1:0]     first_fail_x_o
);

  localparam int NV = 1 << N_IN;
  localparam int CW = N_IN + 1;
  localparam int HW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [HW-1:0] C_SETTLE = HW'(SETTLE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] x_q, x_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NV-1:0]   golden_q, golden_d;
  logic            aborted_q, aborted_d;

  logic start_acc;
  logic sweeping;
  logic settled;
  logic score;
  logic last_vec;
  logic expected;

  assign start_acc = (state_q == ST_IDLE) && start_i && !abort_i;
  assign sweeping  = (state_q == ST_SWEEP);
  assign settled   = (hold_q == C_SETTLE);
  // An abort on the same edge wins, so the vector presented then is never scored.
  assign score     = sweeping && !abort_i && settled;
  assign last_vec  = (x_q == {N_IN{1'b1}});
  assign expected  = golden_q[x_q];

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    hold_d    = hold_q;
    golden_d  = golden_q;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d  = ST_SWEEP;
          x_d      = '0;
          hold_d   = '0;
          golden_d = golden_i;
        end
      end
      ST_SWEEP: begin
        if (abort_i) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (!settled) begin
          hold_d = hold_q + HW'(1);
        end else if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          x_d    = x_q + N_IN'(1);
          hold_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      hold_q    <= '0;
      golden_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      hold_q    <= hold_d;
      golden_q  <= golden_d;
      aborted_q <= aborted_d;
    end
  end

  assign x_o       = x_q;
  assign busy_o    = sweeping;
  assign done_o    = (state_q == ST_DONE);
  assign aborted_o = aborted_q;

  for (genvar j = 0; j < N_FUNC; j++) begin : g_func
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            vld_q, vld_d;
    logic [N_IN-1:0] fx_q, fx_d;
    logic            pass_q, pass_d;
    logic            mism;

    assign mism = score && (f_in_i[j] != expected);

    always_comb begin
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      fx_d   = fx_q;
      pass_d = pass_q;
      if (start_acc) begin
        cnt_d  = '0;
        vld_d  = 1'b0;
        fx_d   = '0;
        pass_d = 1'b0;
      end else begin
        if (mism) begin
          cnt_d = cnt_q + CW'(1);
          if (!vld_q) begin
            vld_d = 1'b1;
            fx_d  = x_q;
          end
        end
        // Pass is judged on the count that includes the final vector's compare.
        if (sweeping && abort_i) begin
          pass_d = 1'b0;
        end else if (score && last_vec) begin
          pass_d = (cnt_d == '0);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        vld_q  <= 1'b0;
        fx_q   <= '0;
        pass_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        vld_q  <= vld_d;
        fx_q   <= fx_d;
        pass_q <= pass_d;
      end
    end

    assign err_cnt_o[j*CW +: CW]        = cnt_q;
    assign first_fail_vld_o[j]          = vld_q;
    assign first_fail_x_o[j*N_IN +: N_IN] = fx_q;
    assign pass_o[j]                    = pass_q;
  end

endmodule
`default_nettype wire
